// File: rtl/intersection_ctrl_pkg.sv
// Shared types and constants for the intersection controller.
// FLASH state exists only when INTERSECTION_FLASH_EN is defined.
package intersection_pkg;

  localparam int DUR_W = 5;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    CLR1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    CLR2   = 3'd5,
    WALK   = 3'd6
`ifdef INTERSECTION_FLASH_EN
    , FLASH = 3'd7
`endif
  } state_e;

  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_OFF    = 3'b000;

  // Short mode halves the green phase length.
  function automatic logic [DUR_W-1:0] green_dur(input logic [DUR_W-1:0] g,
                                                 input logic short_mode);
    return short_mode ? (g >> 1) : g;
  endfunction

endpackage

// File: rtl/intersection_ctrl_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Wrap to zero on the tick cycle, otherwise count up.
  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection scheduler with all-red clearance and pedestrian walk.
// Define INTERSECTION_FLASH_EN to add the night-flash mode and the night input.
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int GREEN_T  = 15,
  parameter int YELLOW_T = 3,
  parameter int CLR_T    = 1,
  parameter int WALK_T   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_short,
  input  logic             car_side,
  input  logic             ped_req,
`ifdef INTERSECTION_FLASH_EN
  input  logic             night,
`endif
  output logic [2:0]       light_main,
  output logic [2:0]       light_side,
  output logic             walk,
  output logic             ped_ack,
  output logic [DUR_W-1:0] down_cnt
);

  localparam logic [DUR_W-1:0] GREEN_D  = DUR_W'(GREEN_T);
  localparam logic [DUR_W-1:0] YELLOW_D = DUR_W'(YELLOW_T);
  localparam logic [DUR_W-1:0] CLR_D    = DUR_W'(CLR_T);
  localparam logic [DUR_W-1:0] WALK_D   = DUR_W'(WALK_T);

  state_e           state_q, state_d, adv_state_s;
  logic [DUR_W-1:0] down_q, down_d, adv_down_s, green_s;
  logic             pend_q, pend_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic             tick_s, rise_s, enter_walk_s, in_flash_s, state_ok_s;
  logic [2:0]       main_s, side_s;
  logic             walk_s;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  assign green_s      = green_dur(GREEN_D, mode_short);
  assign rise_s       = sync2_q & ~prev_q;
  assign enter_walk_s = (state_d == WALK) && (state_q != WALK);
  assign state_ok_s   = (state_q <= WALK) | in_flash_s;

`ifdef INTERSECTION_FLASH_EN
  logic blink_q, blink_d;
  assign in_flash_s = (state_q == FLASH);

  // Blink phase restarts lit on FLASH entry and toggles on every night tick.
  always_comb begin
    blink_d = blink_q;
    if (tick_s && night) begin
      blink_d = in_flash_s ? ~blink_q : 1'b1;
    end else begin
      blink_d = blink_q;
    end
  end

  // Blink register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  assign in_flash_s = 1'b0;
`endif

  // Normal phase advance for a tick; main road rests in green without demand.
  always_comb begin
    adv_state_s = state_q;
    adv_down_s  = down_q;
    if (down_q > 5'd1) begin
      adv_down_s = down_q - 5'd1;
    end else begin
      case (state_q)
        MAIN_G: begin
          if (car_side || pend_q) begin
            adv_state_s = MAIN_Y;
            adv_down_s  = YELLOW_D;
          end else begin
            adv_state_s = MAIN_G;
            adv_down_s  = 5'd1;
          end
        end
        MAIN_Y: begin adv_state_s = CLR1;   adv_down_s = CLR_D;    end
        CLR1:   begin adv_state_s = SIDE_G; adv_down_s = green_s;  end
        SIDE_G: begin adv_state_s = SIDE_Y; adv_down_s = YELLOW_D; end
        SIDE_Y: begin adv_state_s = CLR2;   adv_down_s = CLR_D;    end
        CLR2: begin
          if (pend_q) begin
            adv_state_s = WALK;
            adv_down_s  = WALK_D;
          end else begin
            adv_state_s = MAIN_G;
            adv_down_s  = green_s;
          end
        end
        WALK:    begin adv_state_s = MAIN_G; adv_down_s = green_s; end
        default: begin adv_state_s = CLR2;   adv_down_s = CLR_D;   end
      endcase
    end
  end

  // Next-state selection: illegal encodings recover through all-red CLR2.
  always_comb begin
    state_d = state_q;
    down_d  = down_q;
    if (!state_ok_s) begin
      state_d = CLR2;
      down_d  = CLR_D;
    end else if (tick_s) begin
`ifdef INTERSECTION_FLASH_EN
      if (night) begin
        state_d = FLASH;
        down_d  = {DUR_W{1'b0}};
      end else if (in_flash_s) begin
        state_d = CLR2;
        down_d  = CLR_D;
      end else begin
        state_d = adv_state_s;
        down_d  = adv_down_s;
      end
`else
      state_d = adv_state_s;
      down_d  = adv_down_s;
`endif
    end else begin
      state_d = state_q;
      down_d  = down_q;
    end
  end

  // Pedestrian request latch; clearing on WALK entry beats a simultaneous edge.
  always_comb begin
    sync1_d = ped_req;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pend_d  = pend_q;
    if (enter_walk_s) begin
      pend_d = 1'b0;
    end else if (rise_s && (state_q != WALK) && !in_flash_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // State, countdown and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MAIN_G;
      down_q  <= GREEN_D;
      pend_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      down_q  <= down_d;
      pend_q  <= pend_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Lamp decode; anything unexpected shows all-red.
  always_comb begin
    main_s = LT_RED;
    side_s = LT_RED;
    walk_s = 1'b0;
    case (state_q)
      MAIN_G: begin main_s = LT_GREEN;  side_s = LT_RED;    end
      MAIN_Y: begin main_s = LT_YELLOW; side_s = LT_RED;    end
      SIDE_G: begin main_s = LT_RED;    side_s = LT_GREEN;  end
      SIDE_Y: begin main_s = LT_RED;    side_s = LT_YELLOW; end
      WALK:   begin main_s = LT_RED;    side_s = LT_RED;    walk_s = 1'b1; end
`ifdef INTERSECTION_FLASH_EN
      FLASH: begin
        main_s = blink_q ? LT_YELLOW : LT_OFF;
        side_s = blink_q ? LT_RED : LT_OFF;
      end
`endif
      default: begin main_s = LT_RED; side_s = LT_RED; walk_s = 1'b0; end
    endcase
  end

  assign light_main = main_s;
  assign light_side = side_s;
  assign walk       = walk_s;
  assign ped_ack    = pend_q;
  assign down_cnt   = down_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Randomized self-checking bench for intersection_ctrl against a phase-table model.
module tb_intersection_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_short = 1'b0;
  logic       car_side = 1'b0;
  logic       ped_req = 1'b0;
`ifdef INTERSECTION_FLASH_EN
  logic       night = 1'b0;
`endif
  logic [2:0] light_main, light_side;
  logic       walk, ped_ack;
  logic [4:0] down_cnt;
  logic [12:0] act_vec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  intersection_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_short (mode_short),
    .car_side   (car_side),
    .ped_req    (ped_req),
`ifdef INTERSECTION_FLASH_EN
    .night      (night),
`endif
    .light_main (light_main),
    .light_side (light_side),
    .walk       (walk),
    .ped_ack    (ped_ack),
    .down_cnt   (down_cnt)
  );

  assign act_vec = {light_main, light_side, walk, ped_ack, down_cnt};

  // Reference model: named phase, ticks remaining, request latch, button history.
  string m_ph;
  int    m_rem;
  bit    m_pend, m_blink;
  int    m_edge;
  bit    p1, p2, p3;

  function automatic int green_len();
    return mode_short ? 15 / 2 : 15;
  endfunction

  task automatic model_reset();
    m_ph = "MAIN_G"; m_rem = 15; m_pend = 0; m_blink = 0;
    m_edge = 0; p1 = 0; p2 = 0; p3 = 0;
  endtask

  // Called once per rising clock edge, using input values present at that edge.
  task automatic model_edge();
    bit    rise, tick, nt;
    string ph0;
    m_edge++;
    tick = (m_edge % 4 == 0);
    rise = p2 & ~p3;
    p3 = p2; p2 = p1; p1 = ped_req;
    ph0 = m_ph;
    nt = 0;
`ifdef INTERSECTION_FLASH_EN
    nt = night;
`endif
    if (tick) begin
      if (nt) begin
        m_blink = (m_ph == "FLASH") ? !m_blink : 1'b1;
        m_ph = "FLASH"; m_rem = 0;
      end else if (m_ph == "FLASH") begin
        m_ph = "CLR2"; m_rem = 1;
      end else if (m_rem > 1) begin
        m_rem--;
      end else if (m_ph == "MAIN_G") begin
        if (car_side || m_pend) begin m_ph = "MAIN_Y"; m_rem = 3; end
      end else if (m_ph == "MAIN_Y") begin m_ph = "CLR1";   m_rem = 1;
      end else if (m_ph == "CLR1")   begin m_ph = "SIDE_G"; m_rem = green_len();
      end else if (m_ph == "SIDE_G") begin m_ph = "SIDE_Y"; m_rem = 3;
      end else if (m_ph == "SIDE_Y") begin m_ph = "CLR2";   m_rem = 1;
      end else if (m_ph == "CLR2") begin
        if (m_pend) begin m_ph = "WALK"; m_rem = 8; end
        else begin m_ph = "MAIN_G"; m_rem = green_len(); end
      end else if (m_ph == "WALK") begin m_ph = "MAIN_G"; m_rem = green_len();
      end
    end
    if (m_ph == "WALK" && ph0 != "WALK") m_pend = 0;
    else if (rise && ph0 != "WALK" && ph0 != "FLASH") m_pend = 1;
  endtask

  function automatic logic [12:0] exp_vec();
    logic [2:0] mn, sd;
    logic       wk;
    mn = 3'b100; sd = 3'b100; wk = 1'b0;
    if (m_ph == "MAIN_G") mn = 3'b001;
    else if (m_ph == "MAIN_Y") mn = 3'b010;
    else if (m_ph == "SIDE_G") sd = 3'b001;
    else if (m_ph == "SIDE_Y") sd = 3'b010;
    else if (m_ph == "WALK") wk = 1'b1;
    else if (m_ph == "FLASH") begin
      mn = m_blink ? 3'b010 : 3'b000;
      sd = m_blink ? 3'b100 : 3'b000;
    end
    return {mn, sd, wk, m_pend, 5'(m_rem)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic run_until(input string ph, input int limit, input string tag);
    int i;
    i = 0;
    while (m_ph != ph && i < limit) begin
      step();
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL %s step %0d: got %h expected %h", tag, i, act_vec, exp_vec());
      end
      i++;
    end
    n_cmp++;
    if (m_ph != ph) begin
      n_bad++;
      $display("FAIL %s_reach: phase %s expected %s", tag, m_ph, ph);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (act_vec !== 13'b001_100_0_0_01111) begin
      n_bad++;
      $display("FAIL reset_values: got %h expected %h", act_vec, 13'b001_100_0_0_01111);
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_rest_green();
    do_reset();
    for (int i = 0; i < 160; i++) begin
      step();
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL rest_green step %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    n_cmp++;
    if (down_cnt !== 5'd1 || light_main !== 3'b001) begin
      n_bad++;
      $display("FAIL rest_hold: down_cnt %0d main %b expected 1 001", down_cnt, light_main);
    end
  endtask

  task automatic test_car_side();
    do_reset();
    car_side = 1'b1;
    for (int i = 0; i < 160; i++) begin
      step();
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL car_cycle step %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    car_side = 1'b0;
  endtask

  task automatic test_ped();
    bit got;
    int walk_cyc;
    do_reset();
    car_side = 1'b1;
    run_until("SIDE_G", 120, "ped_to_side");
    repeat (9) step();
    ped_req = 1'b1;
    got = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) ped_req = 1'b0;
      if (ped_ack === 1'b1) got = 1;
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL ped_sync step %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL ped_ack_latency: ped_ack %b expected 1 within 3 clk", ped_ack);
    end
    car_side = 1'b0;
    walk_cyc = 0;
    for (int i = 0; i < 160; i++) begin
      step();
      if (walk === 1'b1) walk_cyc++;
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL ped_walk step %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    n_cmp++;
    if (walk_cyc != 32) begin
      n_bad++;
      $display("FAIL walk_length: got %0d cycles expected 32", walk_cyc);
    end
  endtask

  task automatic test_mode_short();
    int side_cyc;
    do_reset();
    mode_short = 1'b1;
    car_side = 1'b1;
    side_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (i < 120 && light_side === 3'b001) side_cyc++;
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL short_mode step %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    n_cmp++;
    if (side_cyc != 28) begin
      n_bad++;
      $display("FAIL short_side_green: got %0d cycles expected 28", side_cyc);
    end
    mode_short = 1'b0;
    car_side = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    car_side = 1'b1;
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    run_until("SIDE_Y", 200, "mid_to_side_y");
    step();
    n_cmp++;
    if (ped_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pending: ped_ack %b expected 1", ped_ack);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (light_main !== 3'b001 || down_cnt !== 5'd15 || ped_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: main %b down %0d ack %b expected 001 15 0",
               light_main, down_cnt, ped_ack);
    end
    car_side = 1'b0;
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0) car_side = ~car_side;
      if ($urandom_range(0, 9) == 0) ped_req = ~ped_req;
      if ($urandom_range(0, 199) == 0) mode_short = ~mode_short;
      step();
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL random step %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    car_side = 1'b0; ped_req = 1'b0; mode_short = 1'b0;
  endtask

`ifdef INTERSECTION_FLASH_EN
  task automatic test_flash();
    do_reset();
    car_side = 1'b1;
    run_until("SIDE_G", 120, "flash_to_side");
    repeat (8) step();
    night = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL flash step %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    night = 1'b0;
    car_side = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL flash_exit step %0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rest_green();
    test_car_side();
    test_ped();
    test_mode_short();
    test_reset_mid();
    test_random();
`ifdef INTERSECTION_FLASH_EN
    test_flash();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
